// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states, owner ids.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU datapath; codes 101..111 fall through to ADD.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] result
);

    // operation select; all arithmetic wraps at DATA_W bits
    always_comb begin
        case (ctrl)
            ALU_AND: result = data1 & data2;
            ALU_OR:  result = data1 | data2;
            ALU_ADD: result = data1 + data2;
            ALU_SUB: result = data1 - data2;
            ALU_MUL: result = data1 * data2;
            default: result = data1 + data2;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between requesters A and B.
// One operation in flight; result held until its owner accepts it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; ready offered to the granted side
// ST_EXEC | ALU running on captured operands; cnt counts MUL cycles
// ST_RESP | result registered, owner's resp_valid high until accepted
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int          DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data1_i,
    input  logic [DATA_W-1:0] a_data2_i,
    input  logic [2:0]        a_ctrl_i,
    output logic              a_resp_valid_o,
    input  logic              a_resp_ready_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [DATA_W-1:0] b_data1_i,
    input  logic [DATA_W-1:0] b_data2_i,
    input  logic [2:0]        b_ctrl_i,
    output logic              b_resp_valid_o,
    input  logic              b_resp_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    // EXEC lasts cnt+1 cycles, so a multiply loads one less than its length
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            last_grant;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [2:0]        op_ctrl;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] alu_result;
    logic              grant_a;
    logic              grant_b;
    logic [2:0]        sel_ctrl;
    logic              owner_resp_ready;

    alu_share_arbiter_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ctrl   (op_ctrl),
        .data1  (op1),
        .data2  (op2),
        .result (alu_result)
    );

    // round-robin pick: a lone requester wins, contention goes to the side that did not win last
    always_comb begin
        grant_a          = a_valid_i && (!b_valid_i || last_grant == OWN_B);
        grant_b          = b_valid_i && (!a_valid_i || last_grant == OWN_A);
        sel_ctrl         = grant_a ? a_ctrl_i : b_ctrl_i;
        owner_resp_ready = (owner == OWN_A) ? a_resp_ready_i : b_resp_ready_i;
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_a || grant_b) state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == '0)          state_nxt = ST_RESP;
            ST_RESP: if (owner_resp_ready)   state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // handshake outputs; resp_valid is a decode of registered state so it cannot glitch
    always_comb begin
        a_ready_o      = (state == ST_IDLE) && grant_a;
        b_ready_o      = (state == ST_IDLE) && grant_b;
        a_resp_valid_o = (state == ST_RESP) && (owner == OWN_A);
        b_resp_valid_o = (state == ST_RESP) && (owner == OWN_B);
    end

    // operand capture, occupancy counter, result register and fairness history
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            owner      <= OWN_A;
            last_grant <= OWN_B;
            op1        <= '0;
            op2        <= '0;
            op_ctrl    <= ALU_AND;
            cnt        <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_a || grant_b) begin
                        owner   <= grant_a ? OWN_A : OWN_B;
                        op1     <= grant_a ? a_data1_i : b_data1_i;
                        op2     <= grant_a ? a_data2_i : b_data2_i;
                        op_ctrl <= sel_ctrl;
                        cnt     <= (sel_ctrl == ALU_MUL) ? MUL_LOAD : 4'd0;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        result_o <= alu_result;
                        zero_o   <= (alu_result == '0);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (owner_resp_ready) last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

    // only the current owner may ever see a response
    always_ff @(posedge clk_i) begin
        if (rst_i) assert (!(a_resp_valid_o && b_resp_valid_o));
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int MUL_CYCLES = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        a_valid_i = 1'b0, b_valid_i = 1'b0;
    logic        a_ready_o, b_ready_o;
    logic [31:0] a_data1_i = '0, a_data2_i = '0, b_data1_i = '0, b_data2_i = '0;
    logic [2:0]  a_ctrl_i = '0, b_ctrl_i = '0;
    logic        a_resp_valid_o, b_resp_valid_o;
    logic        a_resp_ready_i = 1'b0, b_resp_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;

    int total = 0;
    int bad   = 0;
    int last_model = 1;   // 0 = A won last, 1 = B won last

    alu_share_arbiter #(.MUL_CYCLES(MUL_CYCLES), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .a_valid_i      (a_valid_i),
        .a_ready_o      (a_ready_o),
        .a_data1_i      (a_data1_i),
        .a_data2_i      (a_data2_i),
        .a_ctrl_i       (a_ctrl_i),
        .a_resp_valid_o (a_resp_valid_o),
        .a_resp_ready_i (a_resp_ready_i),
        .b_valid_i      (b_valid_i),
        .b_ready_o      (b_ready_o),
        .b_data1_i      (b_data1_i),
        .b_data2_i      (b_data2_i),
        .b_ctrl_i       (b_ctrl_i),
        .b_resp_valid_o (b_resp_valid_o),
        .b_resp_ready_i (b_resp_ready_i),
        .result_o       (result_o),
        .zero_o         (zero_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd3:    return x - y;
            3'd4:    return p[31:0];
            default: return x + y;
        endcase
    endfunction

    // Runs one transaction starting at a negedge; returns the side whose ready was seen (-1 none).
    task automatic run_op(input bit va, input bit vb,
                          input logic [2:0] ac, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [2:0] bc, input logic [31:0] b1, input logic [31:0] b2,
                          input int delay, input bit keep_valid, input bit other_pulse,
                          input bit early_ready, output int got);
        int w, lat, seen;
        logic [2:0] oc;
        logic [31:0] exp_r;
        logic ov;
        a_valid_i = va; a_ctrl_i = ac; a_data1_i = a1; a_data2_i = a2;
        b_valid_i = vb; b_ctrl_i = bc; b_data1_i = b1; b_data2_i = b2;
        #1;
        if (va && vb) w = (last_model == 1) ? 0 : 1;
        else if (va)  w = 0;
        else          w = 1;
        got = a_ready_o ? 0 : (b_ready_o ? 1 : -1);
        total++;
        if (a_ready_o !== (w == 0) || b_ready_o !== (w == 1)) begin
            bad++;
            $display("FAIL grant: got a_ready=%b b_ready=%b want side %0d", a_ready_o, b_ready_o, w);
        end
        oc    = (w == 0) ? ac : bc;
        exp_r = (w == 0) ? ref_alu(ac, a1, a2) : ref_alu(bc, b1, b2);
        lat   = (oc == 3'd4) ? MUL_CYCLES : 1;
        @(negedge clk_i);
        if (!keep_valid) begin
            a_valid_i = 1'b0;
            b_valid_i = 1'b0;
        end
        a_data1_i = $urandom; a_data2_i = $urandom; a_ctrl_i = 3'($urandom);
        b_data1_i = $urandom; b_data2_i = $urandom; b_ctrl_i = 3'($urandom);
        #1;
        total++;
        if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready: a_ready=%b b_ready=%b want 0 0", a_ready_o, b_ready_o);
        end
        seen = -1;
        for (int j = 0; j <= 40; j++) begin
            ov = (w == 0) ? a_resp_valid_o : b_resp_valid_o;
            if (ov === 1'b1) begin
                seen = j;
                break;
            end
            if (early_ready) begin
                if (w == 0) a_resp_ready_i = 1'b1; else b_resp_ready_i = 1'b1;
            end
            @(negedge clk_i);
            #1;
        end
        a_resp_ready_i = 1'b0;
        b_resp_ready_i = 1'b0;
        total++;
        if (seen != lat) begin
            bad++;
            $display("FAIL latency: got %0d edges want %0d", seen, lat);
            return;
        end
        total++;
        if (result_o !== exp_r || zero_o !== (exp_r == 32'd0)) begin
            bad++;
            $display("FAIL result: got %h zero=%b want %h zero=%b", result_o, zero_o, exp_r, exp_r == 32'd0);
        end
        total++;
        if (((w == 0) ? b_resp_valid_o : a_resp_valid_o) !== 1'b0) begin
            bad++;
            $display("FAIL other_resp_valid: got 1 want 0");
        end
        for (int d = 0; d < delay; d++) begin
            if (w == 0) b_resp_ready_i = 1'b1; else a_resp_ready_i = 1'b1;
            if (other_pulse) begin
                if (w == 0) b_valid_i = 1'b1; else a_valid_i = 1'b1;
            end
            @(negedge clk_i);
            #1;
            total++;
            if (result_o !== exp_r || ((w == 0) ? a_resp_valid_o : b_resp_valid_o) !== 1'b1
                || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL hold: result=%h resp_a=%b resp_b=%b rdy=%b%b want result=%h owner valid, ready 00",
                         result_o, a_resp_valid_o, b_resp_valid_o, a_ready_o, b_ready_o, exp_r);
            end
        end
        a_resp_ready_i = 1'b0;
        b_resp_ready_i = 1'b0;
        if (w == 0) a_resp_ready_i = 1'b1; else b_resp_ready_i = 1'b1;
        @(negedge clk_i);
        a_resp_ready_i = 1'b0;
        b_resp_ready_i = 1'b0;
        #1;
        last_model = w;
        total++;
        if (a_resp_valid_o !== 1'b0 || b_resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL retire: resp_a=%b resp_b=%b want 0 0", a_resp_valid_o, b_resp_valid_o);
        end
        if (other_pulse && delay > 0) begin
            total++;
            if (((w == 0) ? b_ready_o : a_ready_o) !== 1'b1) begin
                bad++;
                $display("FAIL waiting_side_ready: got 0 want 1");
            end
            a_valid_i = 1'b0;
            b_valid_i = 1'b0;
            @(negedge clk_i);
            #1;
            total++;
            if (a_resp_valid_o !== 1'b0 || b_resp_valid_o !== 1'b0 || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL dropped_valid: resp=%b%b ready=%b%b want all 0",
                         a_resp_valid_o, b_resp_valid_o, a_ready_o, b_ready_o);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        a_resp_ready_i = 1'b0; b_resp_ready_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        last_model = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++;
        if (a_resp_valid_o !== 1'b0 || b_resp_valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b0
            || a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: resp=%b%b result=%h zero=%b ready=%b%b want all 0",
                     a_resp_valid_o, b_resp_valid_o, result_o, zero_o, a_ready_o, b_ready_o);
        end
    endtask

    task automatic test_a_only();
        int got;
        @(negedge clk_i);
        run_op(1, 0, 3'b010, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 1, 0, 0, 0, got);
    endtask

    task automatic test_contention();
        int got;
        apply_reset();
        run_op(1, 1, 3'b011, 32'd9, 32'd9, 3'b001, 32'hF0, 32'h0F, 0, 1, 0, 0, got);
        total++;
        if (got != 0) begin bad++; $display("FAIL contention_first: got side %0d want 0", got); end
        run_op(0, 1, 3'b011, 32'd9, 32'd9, 3'b001, 32'hF0, 32'h0F, 0, 0, 0, 0, got);
        total++;
        if (got != 1) begin bad++; $display("FAIL contention_second: got side %0d want 1", got); end
    endtask

    task automatic test_fairness();
        int got;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_op(1, 1, 3'($urandom_range(0, 3)), $urandom, $urandom,
                   3'($urandom_range(0, 3)), $urandom, $urandom, 0, 1, 0, 0, got);
            total++;
            if (got != (i % 2)) begin
                bad++;
                $display("FAIL fairness op %0d: got side %0d want %0d", i, got, i % 2);
            end
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic test_mul();
        int got;
        @(negedge clk_i);
        run_op(1, 0, 3'b100, 32'h10000, 32'h10001, 3'b000, 32'd0, 32'd0, 2, 0, 0, 1, got);
    endtask

    task automatic test_backpressure();
        int got;
        @(negedge clk_i);
        run_op(0, 1, 3'b000, 32'd0, 32'd0, 3'b010, 32'hFFFF_FFFF, 32'd1, 5, 0, 1, 0, got);
    endtask

    task automatic test_reset_mid_exec();
        int got;
        int stray;
        @(negedge clk_i);
        run_op(1, 0, 3'b001, 32'h1, 32'h2, 3'b000, 32'd0, 32'd0, 0, 0, 0, 0, got);
        a_valid_i = 1'b1; a_ctrl_i = 3'b100; a_data1_i = 32'd3; a_data2_i = 32'd4;
        @(negedge clk_i);
        a_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        last_model = 1;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (a_resp_valid_o !== 1'b0 || b_resp_valid_o !== 1'b0) stray++;
            @(negedge clk_i);
        end
        total++;
        if (stray != 0 || result_o !== 32'd0) begin
            bad++;
            $display("FAIL aborted_mul: stray resp cycles=%0d result=%h want 0 and 0", stray, result_o);
        end
        run_op(1, 1, 3'b010, 32'd1, 32'd1, 3'b010, 32'd2, 32'd2, 0, 0, 0, 0, got);
        total++;
        if (got != 0) begin bad++; $display("FAIL post_reset_grant: got side %0d want 0", got); end
    endtask

    task automatic test_random();
        int got;
        bit va, vb;
        logic [31:0] a1, b1;
        @(negedge clk_i);
        for (int i = 0; i < 25; i++) begin
            va = 1'($urandom);
            vb = 1'($urandom);
            if (!va && !vb) va = 1'b1;
            a1 = $urandom;
            b1 = $urandom;
            run_op(va, vb,
                   3'($urandom_range(0, 7)), a1, ($urandom_range(0, 3) == 0) ? a1 : $urandom,
                   3'($urandom_range(0, 7)), b1, ($urandom_range(0, 3) == 0) ? b1 : $urandom,
                   int'($urandom_range(0, 3)), 0, 1'($urandom), 1'($urandom), got);
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_fairness();
        test_mul();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two requesters, A and B.
- A is the pipeline EX stage; B is the auxiliary address/branch unit.
- Provides round-robin arbitration, valid/ready request handshakes and a multi-cycle occupancy window for multiply.
- Holds each result until its owner accepts it; exactly one operation is in flight at any time.

Parameters:
- MUL_CYCLES, 3, EXEC cycles occupied by op 3'b100 (multiply); legal range 1..15.
- DATA_W, 32, operand/result width; fixed at 32 to match the ALU.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- a_valid_i  input  1  requester A has an operation.
- a_ready_o  output  1  A's operation is accepted this cycle.
- a_data1_i  input  32  A operand 1.
- a_data2_i  input  32  A operand 2.
- a_ctrl_i  input  3  A ALU op code.
- a_resp_valid_o  output  1  result_o/zero_o belong to A.
- a_resp_ready_i  input  1  A consumes the response.
- b_valid_i, b_ready_o, b_data1_i, b_data2_i, b_ctrl_i, b_resp_valid_o, b_resp_ready_i: same as A, for requester B.
- result_o  output  32  registered ALU result.
- zero_o  output  1  registered (result == 0).

Behaviour:
- Reset (rst_i low at an edge):
  - State goes to IDLE; a/b_resp_valid_o = 0; result_o = 0; zero_o = 0; cnt = 0.
  - last_grant = B, so A wins the first contention.
  - Reset aborts any in-flight operation; its response is never produced.
- Op semantics, computed by the ALU on the captured operands:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL (low 32 bits).
  - 101..111 behave as ADD.
  - Arithmetic wraps modulo 2^32; no overflow flag.
- a_ready_o / b_ready_o are combinational. They are high only in IDLE, only for the granted requester, and only while that requester's valid is high.
- FSM IDLE:
  - No valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On grant: capture data1, data2, ctrl and owner; set cnt = (ctrl == 100) ? MUL_CYCLES-1 : 0; go to EXEC.
- FSM EXEC:
  - The ALU is driven only from the captured registers.
  - If cnt == 0: register result_o and zero_o, assert the owner's resp_valid_o, go to RESP.
  - Otherwise decrement cnt.
- FSM RESP:
  - Hold resp_valid_o, result_o and zero_o stable.
  - When the owner's resp_ready_i is high: clear resp_valid_o, set last_grant = owner, go to IDLE.
  - A new request is never accepted in the same cycle a response retires.
- Latency, with acceptance at edge N:
  - Non-mul ops: resp_valid visible after edge N+1.
  - MUL: resp_valid visible after edge N+MUL_CYCLES.
  - Minimum issue interval: 3 cycles (non-mul).
- Boundary conditions:
  - resp_ready_i while the matching resp_valid_o is low: ignored.
  - The non-owner's resp_ready_i: ignored.
  - A requester dropping valid before ready: allowed; no state change, last_grant unchanged.
  - Input operand changes after acceptance: no effect.
  - A requester waiting in RESP does not block the other requester's valid from being sampled once the FSM returns to IDLE.
  - Starvation bound: a continuously valid requester is granted within 2 grants.
  - Exactly one of a/b_resp_valid_o can be high at a time (assertion).

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_MUL=3'b100;
  - FSM state encoding ST_IDLE, ST_EXEC, ST_RESP;
  - owner encoding OWN_A = 0, OWN_B = 1.
- Sub-module: instantiate the existing ALU module as the datapath. Arbitration and FSM stay inline; no separate arbiter module.

Test Plan:
- Reset, then A only: a_ctrl=010, 5 + 7 -> a_ready_o=1 in the accept cycle; result_o=12, zero_o=0, a_resp_valid_o=1 two edges later; clears on a_resp_ready_i.
- Simultaneous A and B after reset: A SUB 9-9, B OR 0xF0|0x0F -> A granted first with result 0 and zero_o=1; B granted next with result 0x000000FF.
- Fairness: both valid continuously for 6 ops -> grants alternate A, B, A, B, A, B.
- MUL with MUL_CYCLES=3: 0x10000 * 0x10001 -> response after 3 EXEC cycles; result 0x00010000 (wrapped low bits).
- Backpressure: hold b_resp_ready_i low 5 cycles while a_valid_i is high -> result_o stable, a_ready_o stays 0 until B retires.
- Reset asserted mid-EXEC of a MUL -> no resp_valid ever appears; the next contention is granted to A.
